sti_cmd_feeder: RTL

- Upstream command stage for the serial-transmit/DAC block; it drives that block's load/pi_* interface.
- Fetches 24-bit command words from a synchronous command ROM and presents each one with a one-cycle load pulse.
- Holds the command fields stable for the whole serialization window, then issues the next load at the exact minimum spacing.
- After the last command, asserts pi_end so the downstream block enters its memory-initialize phase.

---
 rtl/sti_cmd_feeder_pkg.sv | 45 ++++
 rtl/sti_cmd_feeder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sti_cmd_feeder_pkg.sv
// Shared definitions for the STI command feeder: command word layout, FSM states, serial width helper.
// Bit positions follow the 24-bit command ROM word; bits above LAST_BIT are reserved.
package sti_cmd_feeder_pkg;

  localparam int CMD_W    = 24;
  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 16;
  localparam int LEN_LSB  = 16;
  localparam int LEN_W    = 2;
  localparam int FILL_BIT = 18;
  localparam int MSB_BIT  = 19;
  localparam int LOW_BIT  = 20;
  localparam int LAST_BIT = 21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_ISSUE,
    S_HOLD,
    S_FINISH
  } state_e;

  typedef struct packed {
    logic              last;
    logic              low;
    logic              msb;
    logic              fill;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic              low;
    logic              msb;
    logic              fill;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] data;
  } pi_t;

  function automatic logic [5:0] serial_bits(input logic [LEN_W-1:0] len);
    return ({4'b0000, len} + 6'd1) << 3;
  endfunction

endpackage

// File: rtl/sti_cmd_feeder.sv
// Fetches command words from a sync ROM and drives the serializer load/pi_* interface; first load 3 cycles after start.
// Loads are spaced exactly W+1 cycles apart (W = serial bits); the next word is prefetched during the hold window.
module sti_cmd_feeder
  import sti_cmd_feeder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cmd_rd_en,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic [CMD_W-1:0]  cmd_rdata,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  cmd_t              buf_q, buf_d;
  pi_t               pi_q, pi_d;
  logic              last_q, last_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]   nxt_q, nxt_d;
  logic              cap_q, cap_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load_q, load_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;

  cmd_t              rd_word;
  cmd_t              src;
  logic              rd_go;
  logic [CMD_W-LAST_BIT-2:0] unused_rsvd;

  assign unused_rsvd = cmd_rdata[CMD_W-1:LAST_BIT+1];

  always_comb begin
    rd_word.data = cmd_rdata[DATA_LSB +: DATA_W];
    rd_word.len  = cmd_rdata[LEN_LSB +: LEN_W];
    rd_word.fill = cmd_rdata[FILL_BIT];
    rd_word.msb  = cmd_rdata[MSB_BIT];
    rd_word.low  = cmd_rdata[LOW_BIT];
    rd_word.last = cmd_rdata[LAST_BIT];
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pi_d    = pi_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    nxt_d   = nxt_q;
    cap_d   = 1'b0;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    load_d  = 1'b0;
    end_d   = end_q;
    src     = buf_q;
    rd_go   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          rd_go   = 1'b1;
        end
      end
      S_FETCH:   state_d = S_CAPTURE;
      S_CAPTURE: begin
        buf_d   = rd_word;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_d   = serial_bits(pi_q.len) - 6'd1;
        state_d = S_HOLD;
        rd_go   = !last_q;
      end
      S_HOLD: begin
        if (cap_q) begin
          buf_d = rd_word;
        end
        if (cnt_q == 6'd0) begin
          state_d = last_q ? S_FINISH : S_ISSUE;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase

    if (rd_go) begin
      rd_en_d = 1'b1;
      addr_d  = nxt_q[ADDR_W-1:0];
      nxt_d   = nxt_q + {{ADDR_W{1'b0}}, 1'b1};
    end
    // Read issued on the first HOLD cycle returns data one cycle later.
    cap_d = rd_en_q && (state_q == S_HOLD);

    if (state_d == S_ISSUE) begin
      src         = (state_q == S_CAPTURE) ? rd_word : buf_q;
      load_d      = 1'b1;
      pi_d.data   = src.data;
      pi_d.len    = src.len;
      pi_d.fill   = src.fill;
      pi_d.msb    = src.msb;
      pi_d.low    = src.low;
      // Once the top address has been fetched there is nothing further to read.
      last_d      = src.last || nxt_q[ADDR_W];
    end

    if (state_d == S_FINISH) begin
      end_d = 1'b1;
    end
    busy_d = (state_d == S_FETCH) || (state_d == S_CAPTURE) ||
             (state_d == S_ISSUE) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      pi_q    <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      nxt_q   <= '0;
      cap_q   <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      load_q  <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pi_q    <= pi_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      nxt_q   <= nxt_d;
      cap_q   <= cap_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd_rd_en = rd_en_q;
  assign cmd_addr  = addr_q;
  assign load      = load_q;
  assign pi_data   = pi_q.data;
  assign pi_length = pi_q.len;
  assign pi_fill   = pi_q.fill;
  assign pi_msb    = pi_q.msb;
  assign pi_low    = pi_q.low;
  assign pi_end    = end_q;
  assign done      = end_q;
  assign busy      = busy_q;

endmodule
